mk_stage_fifo: RTL
==================

MK_STAGE_FIFO -- requirements
Module: mk_stage_fifo

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): NUM_PEGS, 8, PE groups; LOG2_PEGS, 3, log2 of NUM_PEGS; NUM_PES, 8, PEs per group; LOG2_PES, 3, log2 of NUM_PES; DATA_TYPE, 8, element bits; DEPTH, 4, FIFO entries (power of 2, ≥2); LOG2_DEPTH, 2, log2 of DEPTH.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, async active-high reset
- i_clear, in, 1, sync flush of FIFO and block counter
- i_num_blocks, in, 16, MK blocks per pass
- i_wr_valid, in, 1, loader entry valid
- o_wr_ready, out, 1, FIFO can accept
- i_wr_data_bus, in, NUM_PEGS*NUM_PES*DATA_TYPE, MK values
- i_wr_dest_bus, in, NUM_PEGS*NUM_PES*LOG2_PES, destinations
- i_wr_vn_bus, in, NUM_PEGS*NUM_PES*LOG2_PEGS, VN separators
- i_wr_add_bus, in, NUM_PEGS, add flags
- i_wr_block_vn, in, NUM_PEGS*LOG2_PEGS, block VN
- i_wr_accum_ena, in, 2, accumulate mode
- i_data_source, in, 1, scheduler in MK phase
- o_MK_data_valid, out, 1, head entry valid
- o_MK_data_bus / o_MK_dest_bus / o_MK_vn_bus / o_MK_add_bus / o_MK_block_vn / o_MK_accum_ena, out, widths as the matching i_wr_* ports, head entry fields
- o_occupancy, out, LOG2_DEPTH+1, stored entries
- o_done, out, 1, last block of pass consumed

Function
REQ-004 Storage SHALL be DEPTH entries, each holding all six i_wr_* fields, addressed by wrapping write and read pointers plus an occupancy count.
REQ-005 o_wr_ready SHALL be combinational: 1 when o_occupancy != DEPTH, else 0.
REQ-006 A push SHALL occur on a clock edge when i_wr_valid & o_wr_ready; a push is not permitted when full, even if a pop happens in the same cycle.
REQ-007 o_MK_data_valid SHALL be combinational: 1 when o_occupancy != 0.
REQ-008 A pop SHALL occur on a clock edge when i_data_source & o_MK_data_valid, the same cycle the scheduler consumes the MK entry.
REQ-009 The head fields SHALL be first-word fall-through: the entry at the read pointer, with zero latency from pointer update; all o_MK_* fields SHALL be zero while o_MK_data_valid=0.
REQ-010 A push into an empty FIFO SHALL make o_MK_data_valid=1 in the next cycle with that entry on the head (1-cycle latency).
REQ-011 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-012 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-013 The 16-bit block counter SHALL increment on each pop. On a pop with counter == i_num_blocks-1 it SHALL return to 0, and o_done SHALL be 1 for exactly the following cycle (registered).
REQ-014 When i_num_blocks == 0, the counter SHALL hold 0 and o_done SHALL stay 0.
REQ-015 i_clear SHALL take priority over push and pop in the same cycle: pointers, occupancy, block counter and o_done go to 0, and stored contents are don't-care.
REQ-016 A change of i_num_blocks mid-pass SHALL take effect on the next pop comparison; no retroactive o_done SHALL be generated.

Reset
REQ-017 While rst=1 (asynchronous assertion), pointers, occupancy, block counter and o_done SHALL be 0; hence o_wr_ready=1, o_MK_data_valid=0 and all o_MK_* = 0.
REQ-018 Reset asserted mid-operation SHALL discard all entries, and no pop or o_done SHALL occur until after deassertion.
REQ-019 The first push SHALL be accepted on the first clock edge after rst deasserts.

Verification
REQ-020 Fill: i_data_source=0, push 4 entries (data 0x01..0x04 replicated) -> o_occupancy=4, o_wr_ready=0, 5th push refused, head data=0x01.
REQ-021 Drain: from full, i_data_source=1 for 4 cycles -> heads 0x01,0x02,0x03,0x04 in order, then o_MK_data_valid=0 and outputs zero.
REQ-022 Concurrent: occupancy 2, push and pop every cycle for 10 cycles -> occupancy stays 2, pointers wrap, order preserved.
REQ-023 Pass count: i_num_blocks=3, pop 6 entries -> o_done pulses one cycle after the 3rd and 6th pops only; with i_num_blocks=0 o_done never asserts.
REQ-024 Clear/reset: occupancy 3, assert i_clear together with push and pop -> occupancy 0, counter 0, no o_done; repeat with async rst mid-cycle -> outputs zero immediately.
REQ-025 Backpressure: i_data_source toggling 1/0 with the loader pushing continuously -> no entry lost or duplicated, and the pop count equals the push count.

Source files
------------

// File: rtl/mk_stage_fifo_if.sv
// Loader -> MK stage FIFO -> scheduler handshake bundle.
// master: loader/scheduler side, slave: the FIFO.
interface mk_stage_fifo_if #(
  parameter int unsigned NUM_PEGS   = 8,
  parameter int unsigned LOG2_PEGS  = 3,
  parameter int unsigned NUM_PES    = 8,
  parameter int unsigned LOG2_PES   = 3,
  parameter int unsigned DATA_TYPE  = 8,
  parameter int unsigned LOG2_DEPTH = 2
) ();

  logic                                    i_clear;
  logic [15:0]                             i_num_blocks;
  logic                                    i_wr_valid;
  logic                                    o_wr_ready;
  logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]   i_wr_data_bus;
  logic [NUM_PEGS*NUM_PES*LOG2_PES-1:0]    i_wr_dest_bus;
  logic [NUM_PEGS*NUM_PES*LOG2_PEGS-1:0]   i_wr_vn_bus;
  logic [NUM_PEGS-1:0]                     i_wr_add_bus;
  logic [NUM_PEGS*LOG2_PEGS-1:0]           i_wr_block_vn;
  logic [1:0]                              i_wr_accum_ena;
  logic                                    i_data_source;
  logic                                    o_MK_data_valid;
  logic [NUM_PEGS*NUM_PES*DATA_TYPE-1:0]   o_MK_data_bus;
  logic [NUM_PEGS*NUM_PES*LOG2_PES-1:0]    o_MK_dest_bus;
  logic [NUM_PEGS*NUM_PES*LOG2_PEGS-1:0]   o_MK_vn_bus;
  logic [NUM_PEGS-1:0]                     o_MK_add_bus;
  logic [NUM_PEGS*LOG2_PEGS-1:0]           o_MK_block_vn;
  logic [1:0]                              o_MK_accum_ena;
  logic [LOG2_DEPTH:0]                     o_occupancy;
  logic                                    o_done;

  modport master (
    output i_clear, i_num_blocks, i_wr_valid, i_wr_data_bus, i_wr_dest_bus, i_wr_vn_bus,
           i_wr_add_bus, i_wr_block_vn, i_wr_accum_ena, i_data_source,
    input  o_wr_ready, o_MK_data_valid, o_MK_data_bus, o_MK_dest_bus, o_MK_vn_bus,
           o_MK_add_bus, o_MK_block_vn, o_MK_accum_ena, o_occupancy, o_done
  );

  modport slave (
    input  i_clear, i_num_blocks, i_wr_valid, i_wr_data_bus, i_wr_dest_bus, i_wr_vn_bus,
           i_wr_add_bus, i_wr_block_vn, i_wr_accum_ena, i_data_source,
    output o_wr_ready, o_MK_data_valid, o_MK_data_bus, o_MK_dest_bus, o_MK_vn_bus,
           o_MK_add_bus, o_MK_block_vn, o_MK_accum_ena, o_occupancy, o_done
  );

endinterface

// File: rtl/mk_stage_fifo.sv
// MK stage FIFO: first-word fall-through buffer between the MK loader and the
// scheduler, plus a per-pass block counter that flags the last block consumed.
module mk_stage_fifo #(
  parameter int unsigned NUM_PEGS   = 8,
  parameter int unsigned LOG2_PEGS  = 3,
  parameter int unsigned NUM_PES    = 8,
  parameter int unsigned LOG2_PES   = 3,
  parameter int unsigned DATA_TYPE  = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  mk_stage_fifo_if.slave  bus
);

  localparam int unsigned DataW  = NUM_PEGS * NUM_PES * DATA_TYPE;
  localparam int unsigned DestW  = NUM_PEGS * NUM_PES * LOG2_PES;
  localparam int unsigned VnW    = NUM_PEGS * NUM_PES * LOG2_PEGS;
  localparam int unsigned AddW   = NUM_PEGS;
  localparam int unsigned BvnW   = NUM_PEGS * LOG2_PEGS;
  localparam int unsigned AccW   = 2;
  localparam int unsigned EntryW = DataW + DestW + VnW + AddW + BvnW + AccW;

  localparam logic [LOG2_DEPTH:0] OccFull = (LOG2_DEPTH + 1)'(DEPTH);

  logic [EntryW-1:0]     mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   occ_q, occ_d;
  logic [15:0]           blk_cnt_q, blk_cnt_d;
  logic                  done_q, done_d;

  logic                  full, empty, push, pop;
  logic [EntryW-1:0]     wr_entry, head;

  assign full  = (occ_q == OccFull);
  assign empty = (occ_q == '0);
  // Push is gated only by full, so a pop in the same cycle never frees a slot early.
  assign push  = bus.i_wr_valid & ~full;
  assign pop   = bus.i_data_source & ~empty;

  assign wr_entry = {bus.i_wr_accum_ena, bus.i_wr_block_vn, bus.i_wr_add_bus,
                     bus.i_wr_vn_bus, bus.i_wr_dest_bus, bus.i_wr_data_bus};

  // Next-state for pointers, occupancy and pass counter; clear overrides everything.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    blk_cnt_d = blk_cnt_q;
    done_d    = 1'b0;
    if (bus.i_clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      blk_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + (LOG2_DEPTH + 1)'(1);
        2'b01:   occ_d = occ_q - (LOG2_DEPTH + 1)'(1);
        default: occ_d = occ_q;
      endcase
      // Compare against the live block count so a mid-pass change applies at the next pop.
      if (bus.i_num_blocks == 16'd0) begin
        blk_cnt_d = '0;
      end else if (pop) begin
        if (blk_cnt_q == bus.i_num_blocks - 16'd1) begin
          blk_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          blk_cnt_d = blk_cnt_q + 16'd1;
        end
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      blk_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      blk_cnt_q <= blk_cnt_d;
      done_q    <= done_d;
    end
  end

  // Entry storage; contents are never reset since empty entries are masked on read.
  always_ff @(posedge clk) begin
    if (push && !bus.i_clear) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head entry, forced to zero while the FIFO is empty.
  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q];
  end

  assign bus.o_wr_ready      = ~full;
  assign bus.o_MK_data_valid = ~empty;
  assign bus.o_MK_data_bus   = head[0 +: DataW];
  assign bus.o_MK_dest_bus   = head[DataW +: DestW];
  assign bus.o_MK_vn_bus     = head[DataW + DestW +: VnW];
  assign bus.o_MK_add_bus    = head[DataW + DestW + VnW +: AddW];
  assign bus.o_MK_block_vn   = head[DataW + DestW + VnW + AddW +: BvnW];
  assign bus.o_MK_accum_ena  = head[DataW + DestW + VnW + AddW + BvnW +: AccW];
  assign bus.o_occupancy     = occ_q;
  assign bus.o_done          = done_q;

endmodule
